// File: rtl/seq_gen_if.sv
// Handshake bundle for the seq_gen serial pattern transmitter.
// The loop input exists only when SEQ_GEN_LOOP_EN is defined.
interface seq_gen_if #(
    parameter int WIDTH = 8
) ();
    logic             pat_ld;
    logic [WIDTH-1:0] pat_in;
    logic             start;
`ifdef SEQ_GEN_LOOP_EN
    logic             loop;
`endif
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;

    modport master (
`ifdef SEQ_GEN_LOOP_EN
        output loop,
`endif
        output pat_ld, pat_in, start,
        input  dout, dvalid, busy, done
    );

    modport slave (
`ifdef SEQ_GEN_LOOP_EN
        input  loop,
`endif
        input  pat_ld, pat_in, start,
        output dout, dvalid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first, idles high.
// Optional continuous repeat mode is compiled in with SEQ_GEN_LOOP_EN.
//
// state | meaning
// IDLE  | line high, accepts pat_ld and start
// SHIFT | pattern bits on dout, counter tracks bits remaining
// DONE  | last bit emitted; next edge raises done and returns to IDLE
module seq_gen #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PATTERN = 8'b0101_0101
) (
    input logic    clk,
    input logic    rst_n,
    seq_gen_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       rst_q;
    logic             run_ok;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] sreg_q;
    logic [CW-1:0]    cnt_q;
    logic             dout_q;
    logic             dvalid_q;
    logic             busy_q;
    logic             done_q;
    logic             loop_req;
    logic [WIDTH-1:0] load_val;

`ifdef SEQ_GEN_LOOP_EN
    assign loop_req = bus.loop;
`else
    assign loop_req = 1'b0;
`endif

    // Reset asserts asynchronously but releases through two flops before start is honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q <= 2'b00;
        end else begin
            rst_q <= {rst_q[0], 1'b1};
        end
    end

    assign run_ok = rst_q[1];

    always_comb begin
        load_val = pat_q;
        if (bus.pat_ld) begin
            load_val = bus.pat_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pat_q    <= PATTERN;
            sreg_q   <= '1;
            cnt_q    <= '0;
            dout_q   <= 1'b1;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dout_q   <= 1'b1;
                    dvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    if (bus.pat_ld) begin
                        pat_q <= bus.pat_in;
                    end
                    if (bus.start && run_ok) begin
                        state_q  <= SHIFT;
                        dout_q   <= load_val[WIDTH-1];
                        sreg_q   <= {load_val[WIDTH-2:0], 1'b1};
                        cnt_q    <= CNT_LAST;
                        dvalid_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    busy_q   <= 1'b1;
                    dvalid_q <= 1'b1;
                    done_q   <= 1'b0;
                    if (cnt_q == '0) begin
                        // Loop wrap: next frame's MSB follows bit 0 with no gap.
                        dout_q <= pat_q[WIDTH-1];
                        sreg_q <= {pat_q[WIDTH-2:0], 1'b1};
                        cnt_q  <= CNT_LAST;
                    end else begin
                        dout_q <= sreg_q[WIDTH-1];
                        sreg_q <= {sreg_q[WIDTH-2:0], 1'b1};
                        cnt_q  <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE && !loop_req) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    dout_q   <= 1'b1;
                    dvalid_q <= 1'b0;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    dout_q   <= 1'b1;
                    dvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: directed scenarios plus random traffic against a frame-queue model.
// Loop scenarios are included when SEQ_GEN_LOOP_EN is defined.
module tb_seq_gen;
    localparam int             W   = 8;
    localparam logic [W-1:0]   PAT = 8'h55;
`ifdef SEQ_GEN_LOOP_EN
    localparam bit LOOP_BUILD = 1'b1;
`else
    localparam bit LOOP_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_gen_if #(.WIDTH(W)) bus ();

    seq_gen #(.WIDTH(W), .PATTERN(PAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: each accepted frame becomes a list of per-cycle output symbols.
    typedef struct packed {
        logic d;
        logic v;
        logic dn;
        logic last;
    } ent_t;

    ent_t         q[$];
    logic [W-1:0] m_pat = PAT;

    function automatic void push_frame(input logic [W-1:0] p);
        ent_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.d = p[i]; e.v = 1'b1; e.dn = 1'b0; e.last = (i == 0);
            q.push_back(e);
        end
        e.d = 1'b1; e.v = 1'b0; e.dn = 1'b1; e.last = 1'b0;
        q.push_back(e);
    endfunction

    task automatic drive(input logic ld, input logic [W-1:0] pin, input logic st, input logic lp);
        bus.pat_ld = ld;
        bus.pat_in = pin;
        bus.start  = st;
`ifdef SEQ_GEN_LOOP_EN
        bus.loop   = lp;
`endif
    endtask

    task automatic cyc(input logic ld, input logic [W-1:0] pin, input logic st,
                       input logic lp, input string tag);
        ent_t e;
        bit   have;
        drive(ld, pin, st, lp);
        @(posedge clk);
        if (q.size() == 0) begin
            if (ld) m_pat = pin;
            if (st) push_frame(m_pat);
        end
        have = (q.size() != 0);
        e = '0;
        if (have) e = q.pop_front();
        if (LOOP_BUILD && have && e.last && lp) begin
            q.delete();
            push_frame(m_pat);
        end
        #1;
        chk({tag, ".dout"},   32'(bus.dout),   have ? 32'(e.d)  : 32'd1);
        chk({tag, ".dvalid"}, 32'(bus.dvalid), have ? 32'(e.v)  : 32'd0);
        chk({tag, ".done"},   32'(bus.done),   have ? 32'(e.dn) : 32'd0);
        chk({tag, ".busy"},   32'(bus.busy),   have ? 32'd1     : 32'd0);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, tag);
    endtask

    // Called at a negedge; reset lands mid-cycle and outputs must react without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk({tag, ".rst_dout"},   32'(bus.dout),   32'd1);
        chk({tag, ".rst_dvalid"}, 32'(bus.dvalid), 32'd0);
        chk({tag, ".rst_busy"},   32'(bus.busy),   32'd0);
        chk({tag, ".rst_done"},   32'(bus.done),   32'd0);
        q.delete();
        m_pat = PAT;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, {tag, ".sync"});
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset("init");

        cyc(1'b0, '0, 1'b1, 1'b0, "def");
        idle(10, "def");

        cyc(1'b1, 8'hA3, 1'b0, 1'b0, "ld_a3");
        cyc(1'b0, '0, 1'b1, 1'b0, "send_a3");
        idle(10, "send_a3");

        cyc(1'b1, 8'h0F, 1'b1, 1'b0, "ldst_0f");
        idle(10, "ldst_0f");

        cyc(1'b0, '0, 1'b1, 1'b0, "ign");
        idle(2, "ign");
        cyc(1'b1, 8'hFF, 1'b1, 1'b0, "ign_req");
        idle(10, "ign");
        cyc(1'b0, '0, 1'b1, 1'b0, "ign_resend");
        idle(10, "ign_resend");

        cyc(1'b0, '0, 1'b1, 1'b0, "midrst");
        idle(4, "midrst");
        do_reset("midrst");
        cyc(1'b0, '0, 1'b1, 1'b0, "post_rst");
        idle(10, "post_rst");

        for (int i = 0; i < 30; i++) cyc(1'b0, '0, 1'b1, 1'b0, "b2b");
        idle(12, "b2b");

        if (LOOP_BUILD) begin
            cyc(1'b0, '0, 1'b1, 1'b1, "loop");
            for (int i = 0; i < 19; i++) cyc(1'b0, '0, 1'b0, 1'b1, "loop");
            idle(14, "loop_end");
        end

        for (int i = 0; i < 800; i++) begin
            logic           ld, st, lp;
            logic [W-1:0]   pin;
            ld  = ($urandom_range(0, 5) == 0);
            st  = ($urandom_range(0, 3) == 0);
            lp  = ($urandom_range(0, 2) == 0);
            pin = W'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd");
            end else begin
                cyc(ld, pin, st, lp, "rnd");
            end
        end
        idle(30, "drain");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
